// File: rtl/alu_op_sequencer.sv
// Command FIFO and issue/capture sequencer wrapped around the combinational alu8bit.
// Define CHAIN_SEQ_EN to build the prev_result register that feeds chained commands.
module alu_op_sequencer #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned ALU_LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_a,
   input  logic [7:0] cmd_b,
   input  logic [2:0] cmd_op,
   input  logic       cmd_chain,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [2:0] alu_opcode,
   input  logic [7:0] alu_result,
   input  logic [3:0] alu_flags,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_result,
   output logic [3:0] rsp_flags,
   output logic [2:0] rsp_op,
   output logic       rsp_err,
   output logic       busy
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam int unsigned LatW = $clog2(ALU_LAT + 1);
   localparam logic [CntW-1:0] Full    = CntW'(DEPTH);
   localparam logic [LatW-1:0] LatInit = LatW'(ALU_LAT);

   typedef struct packed {
`ifdef CHAIN_SEQ_EN
      logic       chain;
`endif
      logic [2:0] op;
      logic [7:0] b;
      logic [7:0] a;
   } cmd_t;

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   cmd_t            mem_q [DEPTH];
   cmd_t            mem_d [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   state_e          state_q, state_d;
   logic [LatW-1:0] lat_q, lat_d;
   logic [7:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [2:0]      alu_opcode_q, alu_opcode_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [7:0]      rsp_result_q, rsp_result_d;
   logic [3:0]      rsp_flags_q, rsp_flags_d;
   logic [2:0]      rsp_op_q, rsp_op_d;
   logic            rsp_err_q, rsp_err_d;
   logic            push, pop;
   cmd_t            head;

`ifdef CHAIN_SEQ_EN
   logic [7:0]      prev_result_q, prev_result_d;
`else
   logic            unused_chain;
   assign unused_chain = cmd_chain;
`endif

   assign cmd_ready = (count_q < Full);
   assign push      = cmd_valid && cmd_ready;
   // The FSM only ever pops from IDLE, which guarantees the idle cycle between responses.
   assign pop       = (state_q == StIdle) && (count_q != '0);
   assign head      = mem_q[rd_ptr_q];

   always_comb begin : fifo_next
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q].a  = cmd_a;
         mem_d[wr_ptr_q].b  = cmd_b;
         mem_d[wr_ptr_q].op = cmd_op;
`ifdef CHAIN_SEQ_EN
         mem_d[wr_ptr_q].chain = cmd_chain;
`endif
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin : fsm_next
      state_d      = state_q;
      lat_d        = lat_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_opcode_d = alu_opcode_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      rsp_op_d     = rsp_op_q;
      rsp_err_d    = rsp_err_q;
`ifdef CHAIN_SEQ_EN
      prev_result_d = prev_result_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (pop) begin
               if (head.op[2:1] == 2'b11) begin
                  rsp_result_d = '0;
                  rsp_flags_d  = '0;
                  rsp_op_d     = head.op;
                  rsp_err_d    = 1'b1;
                  rsp_valid_d  = 1'b1;
                  state_d      = StResp;
               end else begin
                  alu_a_d = head.a;
`ifdef CHAIN_SEQ_EN
                  if (head.chain) alu_a_d = prev_result_q;
`endif
                  alu_b_d      = head.b;
                  alu_opcode_d = head.op;
                  lat_d        = LatInit;
                  state_d      = StExec;
               end
            end
         end
         StExec: begin
            lat_d = lat_q - LatW'(1);
            if (lat_q == LatW'(1)) begin
               rsp_result_d = alu_result;
               rsp_flags_d  = alu_flags;
               rsp_op_d     = alu_opcode_q;
               rsp_err_d    = 1'b0;
               rsp_valid_d  = 1'b1;
`ifdef CHAIN_SEQ_EN
               prev_result_d = alu_result;
`endif
               state_d = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         state_q      <= StIdle;
         lat_q        <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_opcode_q <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         rsp_op_q     <= '0;
         rsp_err_q    <= 1'b0;
`ifdef CHAIN_SEQ_EN
         prev_result_q <= '0;
`endif
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         state_q      <= state_d;
         lat_q        <= lat_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_opcode_q <= alu_opcode_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         rsp_op_q     <= rsp_op_d;
         rsp_err_q    <= rsp_err_d;
`ifdef CHAIN_SEQ_EN
         prev_result_q <= prev_result_d;
`endif
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_opcode_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_flags  = rsp_flags_q;
   assign rsp_op     = rsp_op_q;
   assign rsp_err    = rsp_err_q;
   assign busy       = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: in-order response model fed from accepted commands, plus a
// second ALU_LAT=3 instance for latency and mid-EXEC reset.
module tb_alu_op_sequencer;

   localparam int Depth = 4;
`ifdef CHAIN_SEQ_EN
   localparam bit ChainEn = 1'b1;
`else
   localparam bit ChainEn = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] r;
      logic [3:0] f;
      logic [2:0] op;
      logic       err;
   } rsp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0, cmd_ready, cmd_chain = 1'b0;
   logic [7:0] cmd_a = '0, cmd_b = '0, alu_a, alu_b, alu_result, rsp_result;
   logic [2:0] cmd_op = '0, alu_opcode, rsp_op;
   logic [3:0] alu_flags, rsp_flags;
   logic       rsp_valid, rsp_ready = 1'b0, rsp_err, busy;

   logic       rst3_n = 1'b0;
   logic       d3_valid = 1'b0, d3_ready, d3_chain = 1'b0;
   logic [7:0] d3_a = '0, d3_b = '0, d3_alu_a, d3_alu_b, d3_alu_result, d3_rsp_result;
   logic [2:0] d3_op = '0, d3_alu_opcode, d3_rsp_op;
   logic [3:0] d3_alu_flags, d3_rsp_flags;
   logic       d3_rsp_valid, d3_rsp_ready = 1'b0, d3_rsp_err, d3_busy;

   int   n_chk = 0, n_fail = 0;
   bit   rnd_ready = 1'b0;
   rsp_t exp_q[$];
   rsp_t got_q[$];
   logic [7:0] m_prev = '0;

   always #5 clk = ~clk;

   // Behavioural alu8bit: flags = {carry/borrow, zero, negative, overflow}.
   function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
      int s;
      logic [7:0] r;
      logic c, v;
      r = '0; c = 1'b0; v = 1'b0;
      case (op)
         3'd0: begin s = int'(a) + int'(b); r = 8'(s); c = s > 255;
                     v = (a[7] == b[7]) && (r[7] != a[7]); end
         3'd1: begin s = int'(a) - int'(b); r = 8'(s); c = s < 0;
                     v = (a[7] != b[7]) && (r[7] != a[7]); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: begin r = {7'b0, a < b}; c = a < b; end
         default: r = '0;
      endcase
      return {c, r == 8'h00, r[7], v, r};
   endfunction

   assign {alu_flags, alu_result}       = alu_f(alu_a, alu_b, alu_opcode);
   assign {d3_alu_flags, d3_alu_result} = alu_f(d3_alu_a, d3_alu_b, d3_alu_opcode);

   alu_op_sequencer #(.DEPTH(Depth), .ALU_LAT(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
      .alu_flags(alu_flags), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_op(rsp_op), .rsp_err(rsp_err),
      .busy(busy)
   );

   alu_op_sequencer #(.DEPTH(Depth), .ALU_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst3_n), .cmd_valid(d3_valid), .cmd_ready(d3_ready),
      .cmd_a(d3_a), .cmd_b(d3_b), .cmd_op(d3_op), .cmd_chain(d3_chain),
      .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_opcode(d3_alu_opcode),
      .alu_result(d3_alu_result), .alu_flags(d3_alu_flags), .rsp_valid(d3_rsp_valid),
      .rsp_ready(d3_rsp_ready), .rsp_result(d3_rsp_result), .rsp_flags(d3_rsp_flags),
      .rsp_op(d3_rsp_op), .rsp_err(d3_rsp_err), .busy(d3_busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected response for an accepted command, in acceptance order.
   task automatic model_push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                             input logic ch);
      rsp_t e;
      logic [11:0] t;
      if (op == 3'd6 || op == 3'd7) begin
         e = '{r: 8'h00, f: 4'h0, op: op, err: 1'b1};
      end else begin
         t = alu_f((ChainEn && ch) ? m_prev : a, b, op);
         e = '{r: t[7:0], f: t[11:8], op: op, err: 1'b0};
         m_prev = t[7:0];
      end
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_ready) rsp_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic ch);
      int n = 0;
      bit acc = 1'b0;
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = ch;
      while (!acc && n < 400) begin
         @(negedge clk);
         acc = cmd_ready;
         tick();
         n++;
      end
      if (acc) model_push(a, b, op, ch);
      else chk("push_timeout", 64'd0, 64'd1);
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 3000) begin
         tick();
         n++;
      end
      chk("drain_done", 64'(exp_q.size() == 0 && !busy), 64'd1);
   endtask

   // Response checker: stability under backpressure and in-order match on every handshake.
   initial begin
      rsp_t cur, held, e;
      bit hold = 1'b0;
      forever begin
         @(negedge clk);
         cur = '{r: rsp_result, f: rsp_flags, op: rsp_op, err: rsp_err};
         if (!rst_n) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               chk("rsp_valid_held", 64'(rsp_valid), 64'd1);
               if (rsp_valid) chk("rsp_stable", 64'(cur), 64'(held));
            end
            if (rsp_valid && rsp_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_rsp", 64'd1, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("rsp_result", 64'(rsp_result), 64'(e.r));
                  chk("rsp_flags", 64'(rsp_flags), 64'(e.f));
                  chk("rsp_op", 64'(rsp_op), 64'(e.op));
                  chk("rsp_err", 64'(rsp_err), 64'(e.err));
                  got_q.push_back(cur);
               end
            end
            hold = rsp_valid && !rsp_ready;
            held = cur;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [7:0] sa, sb;
      logic [2:0] so;
      bit seen;
      int n;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", {alu_a, alu_b, alu_opcode, rsp_valid, rsp_result, rsp_flags, rsp_op,
                         rsp_err, busy}, 64'd0);
      chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1; rst3_n = 1'b1; m_prev = '0;

      // Single add: accepted at T, alu_* at T+1, rsp_valid at T+2.
      push(8'h05, 8'h03, 3'd0, 1'b0);
      @(negedge clk);
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_valid_T", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      chk("t1_alu_ab_op", {alu_a, alu_b, alu_opcode}, {8'h05, 8'h03, 3'd0});
      chk("t1_valid_T1", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      chk("t1_valid_T2", 64'(rsp_valid), 64'd1);
      chk("t1_result", {rsp_result, rsp_err}, {8'h08, 1'b0});
      tick();
      rsp_ready = 1'b1;
      drain();

      // Flag pass-through, back-to-back.
      got_q.delete();
      push(8'h01, 8'h01, 3'd1, 1'b0);
      push(8'h80, 8'h01, 3'd0, 1'b0);
      push(8'hFF, 8'h01, 3'd0, 1'b0);
      drain();
      chk("t2_count", 64'(got_q.size()), 64'd3);
      if (got_q.size() == 3) begin
         chk("t2_r0", {got_q[0].r, got_q[0].f}, {8'h00, 4'b0100});
         chk("t2_r1", {got_q[1].r, got_q[1].f}, {8'h81, 4'b0010});
         chk("t2_r2", {got_q[2].r, got_q[2].f}, {8'h00, 4'b1100});
      end

      // Backpressure: DEPTH+1 commands fill the FIFO while one is held in RESP.
      got_q.delete();
      rsp_ready = 1'b0;
      for (int i = 0; i < Depth + 1; i++) push(8'(16 * i + 1), 8'(i), 3'd0, 1'b0);
      cmd_valid = 1'b1; cmd_a = 8'hAA; cmd_b = 8'h55; cmd_op = 3'd4;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_full_ready", 64'(cmd_ready), 64'd0);
         tick();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      drain();
      chk("t3_count", 64'(got_q.size()), 64'(Depth + 1));

      // Illegal opcode leaves the ALU inputs alone.
      got_q.delete();
      sa = alu_a; sb = alu_b; so = alu_opcode;
      push(8'h12, 8'h34, 3'd6, 1'b0);
      drain();
      chk("t4_alu_hold", {alu_a, alu_b, alu_opcode}, {sa, sb, so});
      push(8'h0F, 8'h01, 3'd2, 1'b0);
      drain();
      if (got_q.size() == 2) begin
         chk("t4_illegal", {got_q[0].r, got_q[0].f, got_q[0].err}, {8'h00, 4'h0, 1'b1});
         chk("t4_legal", {got_q[1].r, got_q[1].err}, {8'h01, 1'b0});
      end else chk("t4_count", 64'(got_q.size()), 64'd2);

      // Chaining: second result is 0x35 with chaining, cmd_a+5 without.
      got_q.delete();
      push(8'h10, 8'h20, 3'd0, 1'b0);
      push(8'h77, 8'h05, 3'd0, 1'b1);
      drain();
      if (got_q.size() == 2) chk("t5_chain", 64'(got_q[1].r), ChainEn ? 64'h35 : 64'h7C);
      else chk("t5_count", 64'(got_q.size()), 64'd2);

      // Random traffic with random backpressure.
      rnd_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) tick();
         push(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom));
      end
      drain();
      rnd_ready = 1'b0;
      rsp_ready = 1'b0;

      // ALU_LAT=3 instance: latency T+1+3.
      d3_valid = 1'b1; d3_a = 8'h02; d3_b = 8'h03; d3_op = 3'd0;
      @(negedge clk);
      chk("d3_ready", 64'(d3_ready), 64'd1);
      tick();
      d3_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("d3_alu_a", 64'(d3_alu_a), 64'h02);
      @(negedge clk);
      @(negedge clk);
      chk("d3_valid_T3", 64'(d3_rsp_valid), 64'd0);
      @(negedge clk);
      chk("d3_rsp_T4", {d3_rsp_valid, d3_rsp_result}, {1'b1, 8'h05});
      tick();
      d3_rsp_ready = 1'b1;
      tick(); tick();
      d3_rsp_ready = 1'b0;

      // Reset mid-EXEC drops the in-flight command.
      d3_valid = 1'b1; d3_a = 8'h40; d3_b = 8'h02; d3_op = 3'd0;
      tick();
      d3_valid = 1'b0;
      tick(); tick();
      @(negedge clk);
      chk("d3_exec_busy", {d3_busy, d3_rsp_valid}, {1'b1, 1'b0});
      rst3_n = 1'b0;
      #1;
      chk("d3_reset_outs", {d3_alu_a, d3_alu_b, d3_alu_opcode, d3_rsp_valid, d3_rsp_result,
                            d3_rsp_flags, d3_rsp_op, d3_rsp_err, d3_busy}, 64'd0);
      chk("d3_reset_ready", 64'(d3_ready), 64'd1);
      tick();
      rst3_n = 1'b1;
      d3_rsp_ready = 1'b1;
      seen = 1'b0;
      for (n = 0; n < 10; n++) begin
         @(negedge clk);
         seen |= d3_rsp_valid | d3_busy;
      end
      chk("d3_no_rsp_after_reset", 64'(seen), 64'd0);

      chk("final_exp_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
